sram_like_mem_arbiter: RTL
==========================

// Module: sram_like_mem_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF-stage fetch master (inst_*) and the
//  MEM-stage load/store master (data_*). Tracks up to OUT_DEPTH accepted-but-unanswered
//  requests in order and routes data_ok/rdata back to the issuing master. Drops responses
//  to fetches cancelled by a WB exception/ertn flush (flush) before they reach IF.
//  Sits between the CPU core and the SRAM-like -> AXI bridge.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width
//  OUT_DEPTH  4   max outstanding accepted requests; power of two, >= 2
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous, active-high reset
//  flush         in   1       WB exception/ertn; cancels all in-flight fetches
//  inst_req      in   1       fetch request (inst_wr is always 0 by convention)
//  inst_addr     in   ADDR_W  fetch address
//  inst_addr_ok  out  1       fetch address accepted
//  inst_data_ok  out  1       fetch data returned
//  inst_rdata    out  DATA_W  fetch data
//  data_req/wr   in   1/1     load/store request; wr=1 store
//  data_size     in   2       0=B,1=H,2=W
//  data_wstrb    in   DATA_W/8  byte enables
//  data_addr     in   ADDR_W  load/store address
//  data_wdata    in   DATA_W  store data
//  data_addr_ok  out  1       data address accepted
//  data_data_ok  out  1       load data returned / store completed
//  data_rdata    out  DATA_W  load data
//  mem_req/wr/size/wstrb/addr/wdata  out  as data_*  muxed downstream request
//  mem_addr_ok   in   1       downstream accepted address
//  mem_data_ok   in   1       downstream response (in order)
//  mem_rdata     in   DATA_W  downstream read data
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, rr pointer=INST; all outputs 0.
//  Handshake: master transfer = req && addr_ok, same cycle. mem_addr_ok goes only to the
//   granted master. The other master's addr_ok = 0.
//  FSM (grant lock; SRAM-like requires req/addr stable until addr_ok):
//   IDLE: FIFO full -> mem_req=0, no grant. Else pick winner (data wins if both).
//     Winner driven on mem_* combinationally. If mem_addr_ok, stay IDLE; else -> HOLD_<winner>.
//   HOLD_INST/HOLD_DATA: mux locked to owner. On mem_addr_ok -> IDLE.
//     Owner req dropping is a master protocol violation. FSM still waits for addr_ok.
//  FIFO entry = {id, discard}. Push on mem_req && mem_addr_ok. Pop on mem_data_ok.
//  Full gates grant even if a pop occurs the same cycle. Simultaneous push+pop when not
//   full is legal, and count is unchanged.
//  Response: head.id routes mem_data_ok/mem_rdata (0-cycle, combinational).
//   head.discard=1 -> inst_data_ok suppressed, entry still popped.
//  flush: sets discard on every valid INST entry. It also sets discard on an INST entry
//   pushed in the same cycle. A same-cycle inst response is itself suppressed.
//   DATA entries are unaffected.
//  mem_data_ok with empty FIFO: ignored, no state change. Benches flag this as an error.
//  Reset mid-transaction: FIFO cleared immediately. Later stale mem_data_ok falls under
//   the empty rule; the bridge is reset together with this block.
//  Latency: 0 added cycles on request and response paths.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: in IDLE with both requests, the master != rr pointer wins.
//   rr pointer updates to the winner on each push.
//  Undefined: fixed priority, data over inst. The rr register is not built.
// STRUCTURE
//  Package mem_arb_pkg: localparams ID_INST=1'b0, ID_DATA=1'b1; FSM encodings
//   S_IDLE/S_HOLD_INST/S_HOLD_DATA; FIFO entry field widths.
//  Sub-module arb_id_fifo: OUT_DEPTH x 2-bit in-order FIFO with push/pop/full/empty and
//   a broadcast "mark all ID_INST entries discard" input. Top holds FSM, mux and routing.
// TESTING
//  1 Single fetch, addr 0x1c000000, mem_addr_ok same cycle, rdata 0x02800401 two cycles
//    later -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x02800401.
//  2 inst_req and data_req (store 0x8000_0000, wstrb 4'hF) together, fixed priority ->
//    data granted first; inst granted next cycle; responses routed DATA then INST.
//  3 mem_addr_ok withheld 3 cycles while data_req rises -> mem_addr stays inst_addr
//    (HOLD_INST), data waits until the inst handshake completes.
//  4 Issue 4 fetches without responses -> 5th gets inst_addr_ok=0 and mem_req=0 (full).
//    One mem_data_ok -> grant resumes next cycle.
//  5 Two fetches outstanding, flush pulsed, a new fetch follows -> first two
//    mem_data_ok give inst_data_ok=0; the third gives inst_data_ok=1.
//  6 ARB_ROUND_ROBIN_EN defined, both masters request continuously -> grants alternate
//    DATA,INST,DATA,INST; rst asserted mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM-like memory arbiter: master IDs, FSM states, ID FIFO entry.
package mem_arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam int unsigned ENTRY_ID_W   = 1;
    localparam int unsigned ENTRY_DISC_W = 1;
    localparam int unsigned ENTRY_W      = ENTRY_ID_W + ENTRY_DISC_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HOLD_INST = 2'd1,
        S_HOLD_DATA = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic id;
        logic discard;
    } arb_entry_t;

    function automatic arb_state_t hold_state(input logic id);
        return (id == ID_DATA) ? S_HOLD_DATA : S_HOLD_INST;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of {id, discard} tags for accepted-but-unanswered requests,
// with a broadcast that marks every fetch entry as discarded.
module arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  arb_entry_t i_push_entry,
    input  logic       i_pop,
    input  logic       i_mark_inst,
    output arb_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(OUT_DEPTH);

    arb_entry_t         r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Stale slots may be marked too; they are overwritten before becoming valid.
            if (i_mark_inst) begin
                for (int i = 0; i < OUT_DEPTH; i++) begin
                    if (r_mem[i].id == ID_INST) begin
                        r_mem[i].discard <= 1'b1;
                    end
                end
            end
            if (w_push) begin
                r_mem[r_wptr] <= i_push_entry;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_mem_arbiter.sv
// Shares one SRAM-like memory port between the fetch and load/store masters.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-over-inst priority.
module sram_like_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_entry_t w_head;
    arb_entry_t w_push_entry;
    logic       w_full;
    logic       w_empty;
    logic       w_run;
    logic       w_sel_valid;
    logic       w_sel_id;
    logic       w_both_winner;
    logic       w_owner_req;
    logic       w_mem_req;
    logic       w_push;
    logic       w_resp;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr;

    assign w_both_winner = (r_rr == ID_INST) ? ID_DATA : ID_INST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= ID_INST;
        end else if (w_push) begin
            r_rr <= w_sel_id;
        end
    end
`else
    assign w_both_winner = ID_DATA;
`endif

    // Outputs are forced low while reset is held, independent of the clock.
    assign w_run = !rst;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = ID_INST;
        case (r_state)
            S_IDLE: begin
                if (!w_full) begin
                    if (data_req && inst_req) begin
                        w_sel_valid = 1'b1;
                        w_sel_id    = w_both_winner;
                    end else if (data_req) begin
                        w_sel_valid = 1'b1;
                        w_sel_id    = ID_DATA;
                    end else if (inst_req) begin
                        w_sel_valid = 1'b1;
                        w_sel_id    = ID_INST;
                    end
                end
            end
            S_HOLD_INST: begin
                w_sel_valid = 1'b1;
                w_sel_id    = ID_INST;
            end
            S_HOLD_DATA: begin
                w_sel_valid = 1'b1;
                w_sel_id    = ID_DATA;
            end
            default: ;
        endcase
    end

    assign w_owner_req = (w_sel_id == ID_DATA) ? data_req : inst_req;
    assign w_mem_req   = w_run && w_sel_valid && w_owner_req;
    assign w_push      = w_mem_req && mem_addr_ok;

    always_comb begin
        mem_req   = w_mem_req;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_mem_req) begin
            if (w_sel_id == ID_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    assign inst_addr_ok = w_push && (w_sel_id == ID_INST);
    assign data_addr_ok = w_push && (w_sel_id == ID_DATA);

    assign w_resp       = w_run && mem_data_ok && !w_empty;
    assign inst_data_ok = w_resp && (w_head.id == ID_INST) && !w_head.discard && !flush;
    assign data_data_ok = w_resp && (w_head.id == ID_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    assign w_push_entry.id      = w_sel_id;
    assign w_push_entry.discard = flush && (w_sel_id == ID_INST);

    arb_id_fifo #(
        .OUT_DEPTH(OUT_DEPTH)
    ) u_id_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_entry(w_push_entry),
        .i_pop       (w_resp),
        .i_mark_inst (flush && w_run),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Grant lock: an un-acknowledged request keeps the mux pinned to its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_req && !mem_addr_ok) begin
                        r_state <= hold_state(w_sel_id);
                    end
                end
                S_HOLD_INST, S_HOLD_DATA: begin
                    if (mem_addr_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
